// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/redirect controller with boot, memory-wait and halt handling
module pipe_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] TRAP_VECTOR  = 32'h100,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_en,
  input  logic        id_en,
  input  logic        ex_en,
  input  logic [4:0]  gpr_rd_addr_0,
  input  logic [4:0]  gpr_rd_addr_1,
  input  logic        id_load,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_addr,
  input  logic        mem_busy,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [31:0] new_pc,
  output logic        new_pc_en,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, HALT = 2'd3} state_t;
  state_t cur, nxt;
  logic [31:0] boot_cnt;
  logic [3:0] stl, fl;
  logic br, lu, boot_last;
  assign state = cur;
  assign {if_stall, id_stall, ex_stall, mem_stall} = stl;
  assign {if_flush, id_flush, ex_flush, mem_flush} = fl;
  assign br = ex_br_taken & ex_en;
  assign boot_last = boot_cnt == 32'(BOOT_CYCLES - 1);
  // a writeback to r0 is discarded, so it can never create a load-use hazard
  assign lu = id_load & id_en & ~id_gpr_we_ & (id_dst_addr != 5'd0) & if_en &
              ((id_dst_addr == gpr_rd_addr_0) | (id_dst_addr == gpr_rd_addr_1));
  always_comb begin
    stl = '0;
    fl = '0;
    new_pc = '0;
    new_pc_en = 1'b0;
    br_taken = 1'b0;
    br_addr = '0;
    nxt = cur;
    if (reset) begin
      stl = 4'hF;
      fl = 4'h8;
      nxt = BOOT;
    end else if (trap_req && cur != BOOT) begin
      fl = 4'hF;
      new_pc = TRAP_VECTOR;
      new_pc_en = 1'b1;
      nxt = RUN;
    end else case (cur)
      BOOT: begin
        stl = 4'hF;
        fl = 4'h8;
        if (boot_last) begin
          new_pc = RESET_VECTOR;
          new_pc_en = 1'b1;
          nxt = RUN;
        end
      end
      RUN:
        if (br) begin
          br_taken = 1'b1;
          br_addr = ex_br_addr;
          fl = 4'hC;
        end else if (mem_busy) begin
          stl = 4'hF;
          nxt = MEM_WAIT;
        end else if (lu) begin
          stl = 4'h8;
          fl = 4'h4;
        end else if (halt_req) nxt = HALT;
      MEM_WAIT: if (mem_busy) stl = 4'hF; else nxt = RUN;
      HALT: begin
        stl = 4'h8;
        fl = 4'h4;
        if (resume_req) nxt = RUN;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= BOOT;
      boot_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cur <= nxt;
      boot_cnt <= cur == BOOT ? boot_cnt + 32'd1 : '0;
      if (if_stall && cur != BOOT && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule
